stall_sched: RTL
================

# stall_sched

Pipeline stall and flush scheduler for the 5-stage MIPS core. It drives the enable inputs of the IF/PC and IF/ID pipeline registers and the clear input of the ID/EX register. It detects load-use and branch-operand hazards and sequences the multi-cycle divider, holding the divide instruction in decode until the divider reports completion. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `CNT_WIDTH`, 16, width of the stall-cycle counter
- `DIV_TIMEOUT`, 40, RUN-state cycle limit before a forced abort (used only with the macro)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; all state is cleared immediately
- `rs_d`, `rt_d`  in  5  source register numbers in decode
- `rt_e`  in  5  rt register number in execute
- `memtoreg_e`  in  1  load instruction in execute
- `regwrite_e`  in  1  execute-stage instruction writes the register file
- `writereg_e`  in  5  destination register in execute
- `memtoreg_m`  in  1  load instruction in memory stage
- `writereg_m`  in  5  destination register in memory stage
- `branch_d`  in  1  branch instruction in decode
- `div_d`  in  1  divide instruction in decode
- `div_done`  in  1  divider result valid; level signal
- `stall_f`  out  1  high holds the PC (PC enable = ~stall_f)
- `stall_d`  out  1  high holds IF/ID (enable = ~stall_d)
- `flush_e`  out  1  high clears ID/EX (inserts a bubble)
- `div_start`  out  1  one-cycle pulse that launches the divider on decode operands
- `div_busy`  out  1  registered; high while the state is RUN
- `div_err`  out  1  one-cycle registered pulse on timeout
- `stall_cnt`  out  CNT_WIDTH  saturating count of cycles with stall_d=1

## Operation
- Hazard terms are combinational.
  - `lwstall` = memtoreg_e & rt_e≠0 & (rt_e==rs_d | rt_e==rt_d).
  - `brstall` = branch_d & ((regwrite_e & writereg_e≠0 & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m≠0 & writereg_m∈{rs_d,rt_d})).
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE: if div_d & ~lwstall & ~brstall, assert div_start and go to RUN. Otherwise stay in IDLE.
  - RUN: if div_done, go to DONE. Otherwise stay in RUN.
  - DONE: go to IDLE unconditionally. div_d is ignored in DONE, because the divide instruction leaves decode in this cycle.
- `divstall` = div_start | (state==RUN).
- Output equations: stall_f = stall_d = flush_e = lwstall | brstall | divstall.
- div_done is sampled only in RUN. It is ignored in IDLE and DONE, and also in the cycle div_start is asserted.
- When lwstall and div_d are both high, the hazard wins. div_start stays low and the divide is retried on a later cycle.
- stall_cnt increments by 1 on each clock edge where stall_d=1. It holds at all-ones and never wraps.

## Timing
- Reset values: state=IDLE, div_busy=0, div_err=0, stall_cnt=0. div_start=0 while in reset.
- During reset, stall_f, stall_d and flush_e follow only lwstall|brstall.
- Divide latency: div_start is asserted in the IDLE cycle T. RUN spans T+1…T+k, where div_done is first high at T+k. DONE is at T+k+1 and releases the stall.
  - Total stall cycles for a divide = 1 + k.
- div_busy is high in cycles T+1…T+k.
- Back-to-back divides: the second div_d is seen in IDLE at T+k+2, so there is exactly one non-stalled cycle (DONE) between the two divides.
- Reset in mid-RUN returns the state to IDLE on the same cycle, with no div_err. The divider shares `reset`.

## Configuration
- `STALL_SCHED_DIV_TIMEOUT_EN` defined:
  - A counter that clears on entry to RUN counts RUN cycles.
  - When the count reaches DIV_TIMEOUT without div_done, the FSM goes to DONE and div_err pulses for one cycle in the DONE cycle.
  - Counter width is clog2(DIV_TIMEOUT+1).
- Macro not defined:
  - No counter is built and div_err is tied to 0.
  - RUN waits indefinitely for div_done.

## Test plan
- Load-use: memtoreg_e=1, rt_e=5, rs_d=5 → stall_f=stall_d=flush_e=1 for that cycle. With rt_e=0 → all three are 0.
- Branch: branch_d=1, regwrite_e=1, writereg_e=rt_d=7 → stall=1. With memtoreg_m=1, writereg_m=rs_d=7 → stall=1. With no match → stall=0.
- Divide: div_d=1 at T, div_done high at T+3 → div_start high only at T, div_busy high T+1…T+3, stall high T…T+3, low at T+4, stall_cnt increases by 4.
- Conflict: div_d=1 with lwstall=1 for 2 cycles, then lwstall=0 → div_start is first asserted in the 3rd cycle.
- Reset mid-RUN: reset asserted at RUN cycle 2 → div_busy=0 and stall_cnt=0 immediately. After release, with div_d=0, stall=0.
- With the macro, DIV_TIMEOUT=4 and div_done held low → 4 RUN cycles, DONE with div_err=1 for one cycle, then IDLE. Without the macro → RUN persists and div_err stays 0.

Source files
------------

// File: rtl/stall_sched.sv
// stall_sched
//
// Pipeline stall and flush scheduler for the 5-stage MIPS core.
// - Detects load-use and branch-operand hazards.
// - Holds a divide instruction in decode while the multi-cycle divider runs.
// - Keeps a saturating count of cycles spent stalled.
//
// Optional feature macro: STALL_SCHED_DIV_TIMEOUT_EN
//   When defined, a RUN-cycle counter aborts a divide after DIV_TIMEOUT cycles
//   without div_done and pulses div_err. When undefined, no counter is built,
//   div_err is tied low and RUN waits for div_done indefinitely.
//
// Parameters:
//   CNT_WIDTH   width of the stall-cycle counter
//   DIV_TIMEOUT RUN-cycle limit before a forced abort (macro builds only)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset; clears all state
//   rs_d, rt_d   in   source registers of the decode-stage instruction
//   rt_e         in   rt register of the execute-stage instruction
//   memtoreg_e   in   execute-stage instruction is a load
//   regwrite_e   in   execute-stage instruction writes the register file
//   writereg_e   in   execute-stage destination register
//   memtoreg_m   in   memory-stage instruction is a load
//   writereg_m   in   memory-stage destination register
//   branch_d     in   decode-stage instruction is a branch
//   div_d        in   decode-stage instruction is a divide
//   div_done     in   divider result valid (level)
//   stall_f      out  holds the PC
//   stall_d      out  holds the IF/ID register
//   flush_e      out  clears ID/EX (bubble)
//   div_start    out  one-cycle pulse launching the divider
//   div_busy     out  registered; high while the divider is running
//   div_err      out  registered one-cycle pulse on divide timeout
//   stall_cnt    out  saturating count of stalled cycles

module stall_sched #(
  parameter int CNT_WIDTH   = 16,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs_d,
  input  logic [4:0]           rt_d,
  input  logic [4:0]           rt_e,
  input  logic                 memtoreg_e,
  input  logic                 regwrite_e,
  input  logic [4:0]           writereg_e,
  input  logic                 memtoreg_m,
  input  logic [4:0]           writereg_m,
  input  logic                 branch_d,
  input  logic                 div_d,
  input  logic                 div_done,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_e,
  output logic                 div_start,
  output logic                 div_busy,
  output logic                 div_err,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic lwstall;
  logic brstall;
  logic divstall;
  logic stall;
  logic ex_fwd_hit;
  logic mem_fwd_hit;

  if (DIV_TIMEOUT < 1) begin : g_bad_timeout
    $error("stall_sched: DIV_TIMEOUT must be at least 1");
  end

  // Load in execute whose target is read by the decode instruction: the
  // value is not available until after the memory stage, so hold one cycle.
  assign lwstall = memtoreg_e && (rt_e != 5'd0) &&
                   ((rt_e == rs_d) || (rt_e == rt_d));

  // Branches resolve in decode, so their operands must already be final.
  // Register 0 is hard-wired and never creates a dependency.
  assign ex_fwd_hit  = regwrite_e && (writereg_e != 5'd0) &&
                       ((writereg_e == rs_d) || (writereg_e == rt_d));
  assign mem_fwd_hit = memtoreg_m && (writereg_m != 5'd0) &&
                       ((writereg_m == rs_d) || (writereg_m == rt_d));
  assign brstall     = branch_d && (ex_fwd_hit || mem_fwd_hit);

  // Launch only when no hazard holds decode this cycle; a hazard wins and the
  // divide is retried later. Gating with reset keeps the divider (which shares
  // reset) from seeing a launch while it is being cleared.
  assign div_start = (state == IDLE) && div_d && !lwstall && !brstall && !reset;

  assign divstall = div_start || (state == RUN);
  assign stall    = lwstall || brstall || divstall;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

`ifdef STALL_SCHED_DIV_TIMEOUT_EN
  localparam int TW = $clog2(DIV_TIMEOUT + 1);

  logic [TW-1:0] run_cnt;

  // Divider sequencing with timeout. run_cnt holds the number of RUN cycles
  // already completed, so the abort fires at the end of RUN cycle DIV_TIMEOUT.
  // A real div_done in that same cycle takes priority and is not an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_busy <= 1'b0;
      div_err  <= 1'b0;
      run_cnt  <= '0;
    end else begin
      div_err <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            state    <= RUN;
            div_busy <= 1'b1;
            run_cnt  <= '0;
          end
        end
        RUN: begin
          if (div_done) begin
            state    <= DONE;
            div_busy <= 1'b0;
          end else if (run_cnt == TW'(DIV_TIMEOUT - 1)) begin
            state    <= DONE;
            div_busy <= 1'b0;
            div_err  <= 1'b1;
          end else begin
            run_cnt <= run_cnt + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          div_busy <= 1'b0;
        end
      endcase
    end
  end
`else
  assign div_err = 1'b0;

  // Divider sequencing without timeout: RUN waits for div_done forever.
  // DONE lasts one cycle so the finished divide can leave decode before a
  // following divide is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            state    <= RUN;
            div_busy <= 1'b1;
          end
        end
        RUN: begin
          if (div_done) begin
            state    <= DONE;
            div_busy <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          div_busy <= 1'b0;
        end
      endcase
    end
  end
`endif

  // Stalled-cycle counter for performance measurement; sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_d && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
